// File: rtl/evm_booth_if.sv
// evm_booth_if: booth console request/code/grant bundle plus the Vote_CU strobe/code bus.
interface evm_booth_if #(
  parameter int NUM_BOOTH = 4
);
  logic [NUM_BOOTH-1:0]   booth_req;
  logic [4*NUM_BOOTH-1:0] booth_code;
  logic [NUM_BOOTH-1:0]   booth_grant;
  logic [NUM_BOOTH-1:0]   booth_done;
  logic                   booth_timeout;
  logic                   cu_ballot;
  logic [3:0]             cu_in;

  modport master (
    output booth_req, booth_code,
    input  booth_grant, booth_done, booth_timeout, cu_ballot, cu_in
  );

  modport slave (
    input  booth_req, booth_code,
    output booth_grant, booth_done, booth_timeout, cu_ballot, cu_in
  );
endinterface

// File: rtl/evm_booth_arbiter.sv
// evm_booth_arbiter: round-robin sharing of one Vote_CU among NUM_BOOTH booth consoles.
// Define EVM_BOOTH_STATS_EN to add per-booth saturating accepted-vote counters (booth_count).
module evm_booth_arbiter #(
  parameter int NUM_BOOTH    = 4,
  parameter int BALLOT_PULSE = 2,
  parameter int VOTE_TIMEOUT = 16,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Power,
  input  logic        Close,
  evm_booth_if.slave  bus,
  output logic [11:0] ballots_cast,
  output logic        busy
`ifdef EVM_BOOTH_STATS_EN
  ,
  output logic [8*NUM_BOOTH-1:0] booth_count
`endif
);

  localparam int IW = $clog2(NUM_BOOTH);
  localparam int CW = $clog2(VOTE_TIMEOUT + BALLOT_PULSE + HOLD_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BALLOT  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        cur_q, cur_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_BOOTH-1:0] grant_q, grant_d;
  logic [NUM_BOOTH-1:0] done_q, done_d;
  logic                 tmo_q, tmo_d;
  logic                 ballot_q, ballot_d;
  logic [3:0]           cuin_q, cuin_d;
  logic [11:0]          cast_q, cast_d;
  logic                 busy_q, busy_d;
  logic                 inc;

  logic                 found;
  logic [IW-1:0]        winner;
  logic [3:0]           code;
  logic                 code_valid;

  // Scan from the round-robin pointer so the booth just served goes to the back of the line.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_BOOTH; k++) begin
      idx = (int'(ptr_q) + k) % NUM_BOOTH;
      if (!found && bus.booth_req[IW'(idx)]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign code       = bus.booth_code[{cur_q, 2'b00} +: 4];
  assign code_valid = (code != 4'd0) && ((code & (code - 4'd1)) == 4'd0);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    done_d   = '0;
    tmo_d    = 1'b0;
    ballot_d = ballot_q;
    cuin_d   = cuin_q;
    cast_d   = cast_q;
    inc      = 1'b0;
    if (!Power) begin
      state_d  = S_IDLE;
      grant_d  = '0;
      ballot_d = 1'b0;
      cuin_d   = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!Close && found) begin
            state_d  = S_BALLOT;
            cur_d    = winner;
            grant_d  = NUM_BOOTH'(1) << winner;
            ballot_d = 1'b1;
            cnt_d    = '0;
            ptr_d    = (int'(winner) == NUM_BOOTH - 1) ? '0 : winner + IW'(1);
          end
        end
        S_BALLOT: begin
          if (cnt_q == CW'(BALLOT_PULSE - 1)) begin
            state_d  = S_WAIT;
            ballot_d = 1'b0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (code_valid) begin
            state_d = S_HOLD;
            cuin_d  = code;
            cnt_d   = '0;
          end else if (cnt_q == CW'(VOTE_TIMEOUT - 1)) begin
            state_d = S_RELEASE;
            grant_d = '0;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_d = S_RELEASE;
            grant_d = '0;
            cuin_d  = '0;
            done_d  = grant_q;
            inc     = 1'b1;
            if (cast_q != 12'hFFF) cast_d = cast_q + 12'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RELEASE: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      tmo_q    <= 1'b0;
      ballot_q <= 1'b0;
      cuin_q   <= '0;
      cast_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      ballot_q <= ballot_d;
      cuin_q   <= cuin_d;
      cast_q   <= cast_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.booth_grant   = grant_q;
  assign bus.booth_done    = done_q;
  assign bus.booth_timeout = tmo_q;
  assign bus.cu_ballot     = ballot_q;
  assign bus.cu_in         = cuin_q;
  assign ballots_cast      = cast_q;
  assign busy              = busy_q;

`ifdef EVM_BOOTH_STATS_EN
  // Counts are retained through Power=0; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      booth_count <= '0;
    end else if (inc) begin
      for (int k = 0; k < NUM_BOOTH; k++) begin
        if (cur_q == IW'(k) && booth_count[8*k +: 8] != 8'hFF)
          booth_count[8*k +: 8] <= booth_count[8*k +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule
